// File: rtl/spi_slave_cs_if.sv
// rtl/spi_slave_cs_if.sv - SPI pins and fabric TX/RX handshake for spi_slave_cs
interface spi_slave_cs_if #(
    parameter int CNT_W = 2
);
    logic             i_SPCK;
    logic             i_MOSI;
    logic             i_CS_n;
    logic             o_MISO;
    logic             o_MISO_En;
    logic [7:0]       i_TX_Byte;
    logic             i_TX_En;
    logic             o_TX_Ready;
    logic             o_TX_Underrun;
    logic [7:0]       o_RX_Byte;
    logic             o_RX_En;
    logic [CNT_W-1:0] o_RX_Count;

    modport slave (
        input  i_SPCK, i_MOSI, i_CS_n, i_TX_Byte, i_TX_En,
        output o_MISO, o_MISO_En, o_TX_Ready, o_TX_Underrun, o_RX_Byte, o_RX_En, o_RX_Count
    );

    modport master (
        output i_SPCK, i_MOSI, i_CS_n, i_TX_Byte, i_TX_En,
        input  o_MISO, o_MISO_En, o_TX_Ready, o_TX_Underrun, o_RX_Byte, o_RX_En, o_RX_Count
    );
endinterface

// File: rtl/spi_slave_cs.sv
// rtl/spi_slave_cs.sv - SPI responder with chip select, oversampled on the system clock
module spi_slave_cs #(
    parameter int         SPI_MODE         = 0,
    parameter int         MAX_BYTES_PER_CS = 3,
    parameter logic [7:0] DEFAULT_TX       = 8'hFF,
    localparam int        CNT_W            = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_slave_cs_if.slave bus
);
    localparam logic             CPOL    = ((SPI_MODE >> 1) & 1) != 0;
    localparam logic             CPHA    = (SPI_MODE & 1) != 0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES_PER_CS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state;
    state_t           next_state;
    logic             frame_start;
    logic             frame_end;
    logic             cs_s1, cs_s2;
    logic             spck_s1, spck_s2, spck_d;
    logic             mosi_s1, mosi_s2;
    logic             in_frame;
    logic             lead, trail;
    logic             sample_ev, shift_ev, byte_start;
    logic [7:0]       tx_shift;
    logic [7:0]       hold;
    logic             hold_full;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_byte;
    logic [2:0]       bit_cnt;
    logic             byte_done;
    logic [CNT_W-1:0] rx_count;
    logic             rx_en;
    logic             underrun;
    logic             miso_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            spck_s1 <= CPOL;
            spck_s2 <= CPOL;
            spck_d  <= CPOL;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            cs_s1   <= bus.i_CS_n;
            cs_s2   <= cs_s1;
            spck_s1 <= bus.i_SPCK;
            spck_s2 <= spck_s1;
            spck_d  <= spck_s2;
            mosi_s1 <= bus.i_MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_s2) begin
                    next_state  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_s2) begin
                    next_state = IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Edges are only meaningful inside a frame; the CS-rising cycle is excluded.
    assign in_frame  = (state == ACTIVE) && !cs_s2;
    assign lead      = in_frame && (spck_d == CPOL) && (spck_s2 != CPOL);
    assign trail     = in_frame && (spck_d != CPOL) && (spck_s2 == CPOL);
    assign sample_ev = CPHA ? trail : lead;
    assign byte_start = CPHA ? (lead && (bit_cnt == 3'd0))
                             : (frame_start || (trail && byte_done));
    assign shift_ev  = (CPHA ? lead : trail) && !byte_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift  <= 8'h00;
            rx_shift  <= 8'h00;
            rx_byte   <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            rx_count  <= '0;
            rx_en     <= 1'b0;
            underrun  <= 1'b0;
            miso_en   <= 1'b0;
        end else begin
            rx_en    <= 1'b0;
            underrun <= 1'b0;
            miso_en  <= (next_state == ACTIVE);
            if (frame_end) begin
                tx_shift  <= 8'h00;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
                rx_count  <= '0;
            end else begin
                if (sample_ev) begin
                    rx_shift <= {rx_shift[6:0], mosi_s2};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_byte   <= {rx_shift[6:0], mosi_s2};
                        rx_en     <= 1'b1;
                        byte_done <= 1'b1;
                        if (rx_count != CNT_MAX) begin
                            rx_count <= rx_count + 1'b1;
                        end
                    end
                end
                // Holding register first, then a same-cycle fabric write, else underrun.
                if (byte_start) begin
                    byte_done <= 1'b0;
                    if (hold_full) begin
                        tx_shift <= hold;
                    end else if (bus.i_TX_En) begin
                        tx_shift <= bus.i_TX_Byte;
                    end else begin
                        tx_shift <= DEFAULT_TX;
                        underrun <= 1'b1;
                    end
                end else if (shift_ev) begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= 8'h00;
            hold_full <= 1'b0;
        end else if (byte_start && hold_full) begin
            hold_full <= 1'b0;
        end else if (bus.i_TX_En && !hold_full && !byte_start) begin
            hold      <= bus.i_TX_Byte;
            hold_full <= 1'b1;
        end
    end

    assign bus.o_MISO        = tx_shift[7];
    assign bus.o_MISO_En     = miso_en;
    assign bus.o_TX_Ready    = ~hold_full;
    assign bus.o_TX_Underrun = underrun;
    assign bus.o_RX_Byte     = rx_byte;
    assign bus.o_RX_En       = rx_en;
    assign bus.o_RX_Count    = rx_count;
endmodule

// File: tb/tb_spi_slave_cs.sv
// tb/tb_spi_slave_cs.sv - four-mode scoreboard bench for spi_slave_cs
module tb_spi_slave_cs;
    localparam int MAXB = 3;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int Q    = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic sclk;
    logic mosi;
    logic cs_n;
    logic junk;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] fd [8];
    logic [7:0] tx_q [4][$];
    logic [7:0] sup_q [4][$];
    logic [7:0] exp_miso [4][$];
    logic [7:0] exp_rx [4][$];
    int         exp_cnt [4][$];
    int         exp_under [4];
    int         obs_under [4];

    wire [3:0]    miso_v;
    wire [3:0]    miso_en_v;
    wire [3:0]    rdy_v;
    wire [3:0]    under_v;
    wire [3:0]    rx_en_v;
    wire [7:0]    rxb_v [4];
    wire [CW-1:0] cnt_v [4];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One master waveform drives every mode; each DUT sees SPCK inverted by its CPOL.
    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam logic CPOL = ((m >> 1) & 1) != 0;

        spi_slave_cs_if #(.CNT_W(CW)) bus ();

        spi_slave_cs #(
            .SPI_MODE(m),
            .MAX_BYTES_PER_CS(MAXB),
            .DEFAULT_TX(8'hFF)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus)
        );

        assign bus.i_SPCK   = sclk ^ CPOL;
        assign bus.i_MOSI   = mosi;
        assign bus.i_CS_n   = cs_n;
        assign miso_v[m]    = bus.o_MISO;
        assign miso_en_v[m] = bus.o_MISO_En;
        assign rdy_v[m]     = bus.o_TX_Ready;
        assign under_v[m]   = bus.o_TX_Underrun;
        assign rx_en_v[m]   = bus.o_RX_En;
        assign rxb_v[m]     = bus.o_RX_Byte;
        assign cnt_v[m]     = bus.o_RX_Count;

        initial begin
            bus.i_TX_En   = 1'b0;
            bus.i_TX_Byte = 8'h00;
            forever begin
                @(negedge clk);
                bus.i_TX_En = 1'b0;
                if (junk) begin
                    bus.i_TX_Byte = 8'h99;
                    bus.i_TX_En   = 1'b1;
                end else if (rst_n && bus.o_TX_Ready && tx_q[m].size() > 0) begin
                    bus.i_TX_Byte = tx_q[m].pop_front();
                    bus.i_TX_En   = 1'b1;
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n && bus.o_TX_Underrun) obs_under[m]++;
            if (rst_n && bus.o_RX_En) begin
                if (exp_rx[m].size() == 0) begin
                    check($sformatf("m%0d_rx_unexpected", m), 32'(bus.o_RX_En), 32'd0);
                end else begin
                    check($sformatf("m%0d_rx_byte", m), 32'(bus.o_RX_Byte), 32'(exp_rx[m].pop_front()));
                    check($sformatf("m%0d_rx_count", m), 32'(bus.o_RX_Count), 32'(exp_cnt[m].pop_front()));
                end
            end
        end
    end

    task automatic supply(input int m, input logic [7:0] b);
        tx_q[m].push_back(b);
        sup_q[m].push_back(b);
    endtask

    task automatic run_frame(input int nbits);
        logic [7:0] mb [4];
        int nfull;
        nfull = nbits / 8;
        // CPHA=0 starts a byte at CS fall and after every complete byte; CPHA=1 per first leading edge.
        for (int m = 0; m < 4; m++) begin
            int slots;
            slots = (m % 2 == 1) ? (nbits + 7) / 8 : nfull + 1;
            for (int s = 0; s < slots; s++) begin
                logic [7:0] b;
                if (sup_q[m].size() > 0) begin
                    b = sup_q[m].pop_front();
                end else begin
                    b = 8'hFF;
                    exp_under[m]++;
                end
                if (s < nfull) exp_miso[m].push_back(b);
            end
            for (int k = 0; k < nfull; k++) begin
                exp_rx[m].push_back(fd[k]);
                exp_cnt[m].push_back((k + 1 < MAXB) ? k + 1 : MAXB);
            end
            mb[m] = 8'h00;
        end
        cs_n = 1'b0;
        repeat (2 * Q) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] cur;
            cur  = fd[i / 8];
            mosi = cur[7 - (i % 8)];
            repeat (Q) @(negedge clk);
            for (int m = 0; m < 4; m += 2) mb[m] = {mb[m][6:0], miso_v[m]};
            if (i == 0) check("miso_en_active", 32'(miso_en_v), 32'hF);
            sclk = 1'b1;
            repeat (2 * Q) @(negedge clk);
            for (int m = 1; m < 4; m += 2) mb[m] = {mb[m][6:0], miso_v[m]};
            sclk = 1'b0;
            repeat (Q) @(negedge clk);
            if (i % 8 == 7) begin
                for (int m = 0; m < 4; m++) begin
                    check($sformatf("m%0d_miso_byte%0d", m, i / 8), 32'(mb[m]), 32'(exp_miso[m].pop_front()));
                end
            end
        end
        repeat (Q) @(negedge clk);
        cs_n = 1'b1;
        repeat (3 * Q) @(negedge clk);
        check("miso_en_idle", 32'(miso_en_v), 32'h0);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("m%0d_underruns", m), 32'(obs_under[m]), 32'(exp_under[m]));
            check($sformatf("m%0d_rx_missing", m), 32'(exp_rx[m].size()), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sclk  = 1'b0;
        mosi  = 1'b0;
        cs_n  = 1'b1;
        junk  = 1'b0;
        for (int m = 0; m < 4; m++) begin
            exp_under[m] = 0;
            obs_under[m] = 0;
        end
        repeat (4) @(negedge clk);
        check("rst_miso", 32'(miso_v), 32'h0);
        check("rst_miso_en", 32'(miso_en_v), 32'h0);
        check("rst_tx_ready", 32'(rdy_v), 32'hF);
        check("rst_underrun", 32'(under_v), 32'h0);
        check("rst_rx_en", 32'(rx_en_v), 32'h0);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("m%0d_rst_rx_byte", m), 32'(rxb_v[m]), 32'h0);
            check($sformatf("m%0d_rst_rx_count", m), 32'(cnt_v[m]), 32'h0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int m = 0; m < 4; m++) supply(m, 8'h3C);
        repeat (4) @(negedge clk);
        fd[0] = 8'hA5;
        run_frame(8);

        for (int m = 0; m < 4; m++) begin
            supply(m, 8'hC1);
            supply(m, 8'hC2);
            supply(m, 8'hC3);
            if (m % 2 == 0) supply(m, 8'hC4);
        end
        repeat (4) @(negedge clk);
        check("tx_ready_full", 32'(rdy_v), 32'h0);
        junk = 1'b1;
        repeat (2) @(negedge clk);
        junk = 1'b0;
        repeat (2) @(negedge clk);
        fd[0] = 8'h11;
        fd[1] = 8'h22;
        fd[2] = 8'h33;
        run_frame(24);

        fd[0] = 8'h5E;
        fd[1] = 8'hE7;
        run_frame(16);

        for (int m = 0; m < 4; m++) supply(m, 8'h5A);
        repeat (4) @(negedge clk);
        fd[0] = 8'hB4;
        run_frame(5);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("m%0d_abort_count", m), 32'(cnt_v[m]), 32'd0);
        end
        fd[0] = 8'h96;
        run_frame(8);

        for (int k = 0; k < 5; k++) fd[k] = 8'(k + 1);
        run_frame(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
